// File: rtl/man_deframe_dec_if.sv
// Coded-word input and decoded-byte output bundle of the Manchester deframer.
// The source side drives coded_*; the deframer drives dec_*, lock and counters.
interface man_deframe_dec_if;
  logic        coded_val;
  logic [15:0] coded_data;
  logic        dec_val;
  logic        dec_sof;
  logic        dec_eof;
  logic [7:0]  dec_data;
  logic        dec_err;
  logic        sync_lock;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  modport master (
    output coded_val, coded_data,
    input  dec_val, dec_sof, dec_eof, dec_data, dec_err, sync_lock, frame_cnt, err_cnt
  );

  modport slave (
    input  coded_val, coded_data,
    output dec_val, dec_sof, dec_eof, dec_data, dec_err, sync_lock, frame_cnt, err_cnt
  );
endinterface

// File: rtl/man_deframe_dec.sv
// Sync-header hunter and Manchester decoder: locks on SYNC_NUM sync words,
// decodes each 16-bit word to one byte and frames bytes with sof/eof.
module man_deframe_dec #(
  parameter logic [15:0] SYNC_WORD = 16'hF0F0,
  parameter int          SYNC_NUM  = 2,
  parameter int          MAX_BYTES = 2048
) (
  input  logic              i_vl_tx_clk,
  input  logic              i_vl_tx_rst_n,
  man_deframe_dec_if.slave  bus,
  output logic [1:0]        dbg_state
);
  // Handshake: coded_val qualifies coded_data every cycle with no backpressure;
  // dec_val is a one-cycle pulse that the consumer must take when it is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_e;

  localparam logic [3:0]  SYNC_NUM_L  = 4'(SYNC_NUM);
  localparam logic [15:0] MAX_L       = 16'(MAX_BYTES);
  localparam logic        MAX_IS_ONE  = (MAX_BYTES == 1);

  state_e      state, state_n;
  logic [3:0]  sync_cnt, sync_cnt_n, sync_inc;
  logic [15:0] byte_cnt, byte_cnt_n, byte_inc;
  logic [7:0]  hold_data, hold_data_n;
  logic        hold_err, hold_err_n;
  logic        hold_sof, hold_sof_n;
  logic        hold_last, hold_last_n;
  logic        emit, emit_eof, load;
  logic        sync_hit, data_hit;
  logic [7:0]  dec_byte;
  logic        dec_bad;

  assign sync_hit  = bus.coded_val && (bus.coded_data == SYNC_WORD);
  assign data_hit  = bus.coded_val && (bus.coded_data != SYNC_WORD);
  assign sync_inc  = sync_cnt + 4'd1;
  assign byte_inc  = byte_cnt + 16'd1;
  assign dbg_state = state;

  // Illegal pairs (00/11) still yield their upper bit so the byte stays usable.
  always_comb begin
    dec_byte = '0;
    dec_bad  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      dec_byte[k] = bus.coded_data[2*k+1];
      dec_bad     = dec_bad | (bus.coded_data[2*k+1] == bus.coded_data[2*k]);
    end
  end

  always_comb begin
    state_n     = state;
    sync_cnt_n  = sync_cnt;
    byte_cnt_n  = byte_cnt;
    hold_data_n = hold_data;
    hold_err_n  = hold_err;
    hold_sof_n  = hold_sof;
    hold_last_n = hold_last;
    emit        = 1'b0;
    emit_eof    = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (sync_hit) begin
          if (sync_inc == SYNC_NUM_L) begin
            state_n    = SYNC;
            sync_cnt_n = '0;
          end else begin
            sync_cnt_n = sync_inc;
          end
        end else begin
          sync_cnt_n = '0;
        end
      end
      SYNC: begin
        if (!bus.coded_val) begin
          state_n = IDLE;
        end else if (data_hit) begin
          state_n     = DATA;
          load        = 1'b1;
          hold_sof_n  = 1'b1;
          byte_cnt_n  = 16'd1;
          hold_last_n = MAX_IS_ONE;
        end
      end
      DATA: begin
        // Every event in DATA releases the held byte; only its eof flag differs.
        emit = 1'b1;
        if (!bus.coded_val) begin
          emit_eof = 1'b1;
          state_n  = IDLE;
        end else if (sync_hit) begin
          emit_eof = 1'b1;
          if (SYNC_NUM_L == 4'd1) begin
            state_n    = SYNC;
            sync_cnt_n = '0;
          end else begin
            state_n    = IDLE;
            sync_cnt_n = 4'd1;
          end
        end else if (hold_last) begin
          emit_eof = 1'b1;
          state_n  = DROP;
        end else begin
          load        = 1'b1;
          hold_sof_n  = 1'b0;
          byte_cnt_n  = byte_inc;
          hold_last_n = (byte_inc == MAX_L);
        end
      end
      DROP: begin
        if (!bus.coded_val) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      hold_data_n = dec_byte;
      hold_err_n  = dec_bad;
    end
  end

  always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
    if (!i_vl_tx_rst_n) begin
      state         <= IDLE;
      sync_cnt      <= '0;
      byte_cnt      <= '0;
      hold_data     <= '0;
      hold_err      <= 1'b0;
      hold_sof      <= 1'b0;
      hold_last     <= 1'b0;
      bus.dec_val   <= 1'b0;
      bus.dec_sof   <= 1'b0;
      bus.dec_eof   <= 1'b0;
      bus.dec_data  <= '0;
      bus.dec_err   <= 1'b0;
      bus.sync_lock <= 1'b0;
      bus.frame_cnt <= '0;
      bus.err_cnt   <= '0;
    end else begin
      state         <= state_n;
      sync_cnt      <= sync_cnt_n;
      byte_cnt      <= byte_cnt_n;
      hold_data     <= hold_data_n;
      hold_err      <= hold_err_n;
      hold_sof      <= hold_sof_n;
      hold_last     <= hold_last_n;
      bus.dec_val   <= emit;
      bus.dec_sof   <= emit & hold_sof;
      bus.dec_eof   <= emit_eof;
      bus.dec_err   <= emit & hold_err;
      if (emit) begin
        bus.dec_data <= hold_data;
      end
      bus.sync_lock <= (state_n == SYNC) || (state_n == DATA);
      // Counters follow the registered output pulses, so they lag by one cycle.
      bus.frame_cnt <= bus.frame_cnt + {15'd0, bus.dec_val & bus.dec_eof};
      if (bus.dec_val && bus.dec_err && (bus.err_cnt != 16'hFFFF)) begin
        bus.err_cnt <= bus.err_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_man_deframe_dec.sv
// Bench for man_deframe_dec: three instances (default, SYNC_NUM=1, MAX_BYTES=4)
// share one coded stream; outputs are checked against constants and a frame model.
module tb_man_deframe_dec;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drv_val = 1'b0;
  logic [15:0] drv_data = '0;
  logic [1:0]  st_a, st_b, st_c;

  always #5 clk = ~clk;

  man_deframe_dec_if bus_a ();
  man_deframe_dec_if bus_b ();
  man_deframe_dec_if bus_c ();

  assign bus_a.coded_val  = drv_val;
  assign bus_a.coded_data = drv_data;
  assign bus_b.coded_val  = drv_val;
  assign bus_b.coded_data = drv_data;
  assign bus_c.coded_val  = drv_val;
  assign bus_c.coded_data = drv_data;

  man_deframe_dec u_a (.i_vl_tx_clk(clk), .i_vl_tx_rst_n(rst_n), .bus(bus_a), .dbg_state(st_a));
  man_deframe_dec #(.SYNC_NUM(1)) u_b (.i_vl_tx_clk(clk), .i_vl_tx_rst_n(rst_n), .bus(bus_b), .dbg_state(st_b));
  man_deframe_dec #(.MAX_BYTES(4)) u_c (.i_vl_tx_clk(clk), .i_vl_tx_rst_n(rst_n), .bus(bus_c), .dbg_state(st_c));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int base = 0;

  // Entry layout: {cycle[15:0], sof, eof, err, data[7:0]}; cycle is the stream
  // index of the word whose sampling released the byte.
  logic [26:0] act_a[$], act_b[$], act_c[$];
  logic [26:0] exp_q[$];
  logic [16:0] stim_q[$];
  logic [24:0] model_frame[$];
  int          exp_frames, exp_errs;
  bit          lock_seen_a;
  logic        lock_sof_a, lock_eof_c;

  // ---------------- clock/reset + monitors ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.sync_lock) lock_seen_a = 1'b1;
    if (bus_a.dec_val) begin
      act_a.push_back({16'(cyc - base - 1), bus_a.dec_sof, bus_a.dec_eof, bus_a.dec_err, bus_a.dec_data});
      if (bus_a.dec_sof) lock_sof_a = bus_a.sync_lock;
    end
    if (bus_b.dec_val)
      act_b.push_back({16'(cyc - base - 1), bus_b.dec_sof, bus_b.dec_eof, bus_b.dec_err, bus_b.dec_data});
    if (bus_c.dec_val) begin
      act_c.push_back({16'(cyc - base - 1), bus_c.dec_sof, bus_c.dec_eof, bus_c.dec_err, bus_c.dec_data});
      if (bus_c.dec_eof) lock_eof_c = bus_c.sync_lock;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers and driver tasks ----------------
  function automatic logic [26:0] ent(input int c, input bit sof, input bit eof, input bit err, input logic [7:0] d);
    return {16'(c), sof, eof, err, d};
  endfunction

  function automatic logic [15:0] enc(input logic [7:0] b);
    logic [15:0] w;
    for (int k = 0; k < 8; k++) w[2*k +: 2] = b[k] ? 2'b10 : 2'b01;
    return w;
  endfunction

  task automatic push_w(input logic [15:0] w);
    stim_q.push_back({1'b1, w});
  endtask

  task automatic push_gap(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(17'd0);
  endtask

  task automatic apply_reset();
    drv_val = 1'b0;
    drv_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    act_a.delete(); act_b.delete(); act_c.delete();
    stim_q.delete(); exp_q.delete();
    lock_seen_a = 1'b0;
    lock_sof_a = 1'b0;
    lock_eof_c = 1'b1;
  endtask

  task automatic drive_stream();
    @(negedge clk);
    base = cyc;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      drv_val  = stim_q[i][16];
      drv_data = stim_q[i][15:0];
    end
    @(negedge clk);
    drv_val = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Frames are collected as whole byte lists and released when they end; each
  // byte appears one word after the word that carried it.
  task automatic flush_frame();
    for (int j = 0; j < model_frame.size(); j++) begin
      exp_q.push_back({16'(model_frame[j][24:9] + 16'd1), j == 0, j == model_frame.size() - 1,
                       model_frame[j][8], model_frame[j][7:0]});
      exp_errs += int'(model_frame[j][8]);
    end
    if (model_frame.size() > 0) exp_frames++;
    model_frame.delete();
  endtask

  task automatic run_model(input int sync_num, input int max_bytes);
    int run = 0;
    bit locked = 0, dropping = 0;
    logic [16:0] w;
    logic [7:0] b;
    bit bad;
    exp_q.delete();
    model_frame.delete();
    exp_frames = 0;
    exp_errs = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      w = stim_q[i];
      if (!w[16]) begin
        flush_frame();
        locked = 0; dropping = 0; run = 0;
      end else if (dropping) begin
        // discarded
      end else if (w[15:0] == 16'hF0F0) begin
        if (model_frame.size() > 0) begin
          flush_frame();
          run = 1;
          locked = (sync_num == 1);
        end else if (!locked) begin
          run++;
          if (run == sync_num) locked = 1;
        end
      end else if (model_frame.size() == max_bytes) begin
        flush_frame();
        dropping = 1; locked = 0;
      end else if (model_frame.size() > 0 || locked) begin
        bad = 0;
        for (int k = 0; k < 8; k++) begin
          b[k] = w[2*k+1];
          if (w[2*k+1] == w[2*k]) bad = 1;
        end
        model_frame.push_back({16'(i), bad, b});
      end else begin
        run = 0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [44:0] o;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv_val  = i[0];
      drv_data = (i % 4 < 2) ? 16'hF0F0 : 16'($urandom);
      o = {bus_a.dec_val, bus_a.dec_sof, bus_a.dec_eof, bus_a.dec_err, bus_a.dec_data,
           bus_a.sync_lock, bus_a.frame_cnt, bus_a.err_cnt, st_a, 1'b0};
      n_cmp++;
      if (o !== 45'd0) begin n_fail++; $display("FAIL reset_hold: got %h expected 0", o); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drv_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o = {bus_a.dec_val, bus_a.dec_sof, bus_a.dec_eof, bus_a.dec_err, bus_a.dec_data,
           bus_a.sync_lock, bus_a.frame_cnt, bus_a.err_cnt, st_a, 1'b0};
      n_cmp++;
      if (o !== 45'd0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", o); end
    end
  endtask

  task automatic test_normal();
    apply_reset();
    push_w(16'hF0F0); push_w(16'hF0F0); push_w(16'h9966); push_w(16'h5555); push_w(16'hAAAA); push_gap(2);
    drive_stream();
    exp_q = '{ent(3, 1, 0, 0, 8'hA5), ent(4, 0, 0, 0, 8'h00), ent(5, 0, 1, 0, 8'hFF)};
    n_cmp++;
    if (act_a.size() != 3) begin n_fail++; $display("FAIL normal_count: got %0d expected 3", act_a.size()); end
    for (int i = 0; i < 3 && i < act_a.size(); i++) begin
      n_cmp++;
      if (act_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL normal_byte%0d: got %h expected %h", i, act_a[i], exp_q[i]); end
    end
    n_cmp++;
    if (bus_a.frame_cnt !== 16'd1) begin n_fail++; $display("FAIL normal_frame_cnt: got %0d expected 1", bus_a.frame_cnt); end
    n_cmp++;
    if (bus_a.err_cnt !== 16'd0) begin n_fail++; $display("FAIL normal_err_cnt: got %0d expected 0", bus_a.err_cnt); end
    n_cmp++;
    if (lock_sof_a !== 1'b1) begin n_fail++; $display("FAIL normal_lock_at_sof: got %b expected 1", lock_sof_a); end
    n_cmp++;
    if (bus_a.sync_lock !== 1'b0) begin n_fail++; $display("FAIL normal_lock_after: got %b expected 0", bus_a.sync_lock); end
  endtask

  task automatic test_insufficient_sync();
    apply_reset();
    push_w(16'hF0F0); push_w(16'h9966); push_w(16'h5555); push_gap(2);
    drive_stream();
    n_cmp++;
    if (act_a.size() != 0) begin n_fail++; $display("FAIL insuf_no_val: got %0d bytes expected 0", act_a.size()); end
    n_cmp++;
    if (lock_seen_a !== 1'b0) begin n_fail++; $display("FAIL insuf_no_lock: got %b expected 0", lock_seen_a); end
    exp_q = '{ent(2, 1, 0, 0, 8'hA5), ent(3, 0, 1, 0, 8'h00)};
    n_cmp++;
    if (act_b.size() != 2) begin n_fail++; $display("FAIL sync1_count: got %0d expected 2", act_b.size()); end
    for (int i = 0; i < 2 && i < act_b.size(); i++) begin
      n_cmp++;
      if (act_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL sync1_byte%0d: got %h expected %h", i, act_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_illegal_pair();
    apply_reset();
    push_w(16'hF0F0); push_w(16'hF0F0); push_w(16'h9967); push_w(16'hAAAA); push_gap(2);
    drive_stream();
    exp_q = '{ent(3, 1, 0, 1, 8'hA5), ent(4, 0, 1, 0, 8'hFF)};
    n_cmp++;
    if (act_a.size() != 2) begin n_fail++; $display("FAIL illegal_count: got %0d expected 2", act_a.size()); end
    for (int i = 0; i < 2 && i < act_a.size(); i++) begin
      n_cmp++;
      if (act_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL illegal_byte%0d: got %h expected %h", i, act_a[i], exp_q[i]); end
    end
    n_cmp++;
    if (bus_a.err_cnt !== 16'd1) begin n_fail++; $display("FAIL illegal_err_cnt: got %0d expected 1", bus_a.err_cnt); end
    n_cmp++;
    if (bus_a.frame_cnt !== 16'd1) begin n_fail++; $display("FAIL illegal_frame_cnt: got %0d expected 1", bus_a.frame_cnt); end
  endtask

  task automatic test_length_limit();
    apply_reset();
    push_w(16'hF0F0); push_w(16'hF0F0);
    for (int i = 0; i < 6; i++) push_w(16'h5555);
    push_gap(2);
    drive_stream();
    exp_q = '{ent(3, 1, 0, 0, 8'h00), ent(4, 0, 0, 0, 8'h00), ent(5, 0, 0, 0, 8'h00), ent(6, 0, 1, 0, 8'h00)};
    n_cmp++;
    if (act_c.size() != 4) begin n_fail++; $display("FAIL maxlen_count: got %0d expected 4", act_c.size()); end
    for (int i = 0; i < 4 && i < act_c.size(); i++) begin
      n_cmp++;
      if (act_c[i] !== exp_q[i]) begin n_fail++; $display("FAIL maxlen_byte%0d: got %h expected %h", i, act_c[i], exp_q[i]); end
    end
    n_cmp++;
    if (bus_c.frame_cnt !== 16'd1) begin n_fail++; $display("FAIL maxlen_frame_cnt: got %0d expected 1", bus_c.frame_cnt); end
    n_cmp++;
    if (lock_eof_c !== 1'b0) begin n_fail++; $display("FAIL maxlen_lock_at_eof: got %b expected 0", lock_eof_c); end
    n_cmp++;
    if (act_a.size() != 6) begin n_fail++; $display("FAIL maxlen_default_count: got %0d expected 6", act_a.size()); end
  endtask

  task automatic test_sync_in_data();
    apply_reset();
    push_w(16'hF0F0); push_w(16'hF0F0); push_w(16'hAAAA);
    push_w(16'hF0F0); push_w(16'hF0F0); push_w(16'h9966); push_gap(2);
    drive_stream();
    exp_q = '{ent(3, 1, 1, 0, 8'hFF), ent(6, 1, 1, 0, 8'hA5)};
    n_cmp++;
    if (act_a.size() != 2) begin n_fail++; $display("FAIL syncdata_count: got %0d expected 2", act_a.size()); end
    for (int i = 0; i < 2 && i < act_a.size(); i++) begin
      n_cmp++;
      if (act_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL syncdata_byte%0d: got %h expected %h", i, act_a[i], exp_q[i]); end
    end
    n_cmp++;
    if (bus_a.frame_cnt !== 16'd2) begin n_fail++; $display("FAIL syncdata_frame_cnt: got %0d expected 2", bus_a.frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [44:0] o;
    apply_reset();
    @(negedge clk);
    base = cyc;
    drv_val = 1'b1; drv_data = 16'hF0F0;
    @(negedge clk); drv_data = 16'hF0F0;
    @(negedge clk); drv_data = 16'h9966;
    @(negedge clk); drv_data = 16'h5555;
    @(negedge clk); drv_data = 16'hAAAA;
    #2;
    rst_n = 1'b0;
    #1;
    o = {bus_a.dec_val, bus_a.dec_sof, bus_a.dec_eof, bus_a.dec_err, bus_a.dec_data,
         bus_a.sync_lock, bus_a.frame_cnt, bus_a.err_cnt, st_a, 1'b0};
    n_cmp++;
    if (o !== 45'd0) begin n_fail++; $display("FAIL midrst_async_clear: got %h expected 0", o); end
    repeat (2) @(negedge clk);
    drv_val = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (act_a.size() != 1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", act_a.size()); end
    else begin
      n_cmp++;
      if (act_a[0] !== ent(3, 1, 0, 0, 8'hA5)) begin
        n_fail++; $display("FAIL midrst_byte: got %h expected %h", act_a[0], ent(3, 1, 0, 0, 8'hA5));
      end
    end
    n_cmp++;
    if ({bus_a.frame_cnt, bus_a.err_cnt} !== 32'd0) begin
      n_fail++; $display("FAIL midrst_counters: got %h expected 0", {bus_a.frame_cnt, bus_a.err_cnt});
    end
  endtask

  task automatic test_random();
    logic [26:0] act[$];
    int          sn, mb;
    logic [15:0] fc, ec;
    apply_reset();
    for (int f = 0; f < 40; f++) begin
      push_gap($urandom_range(1, 3));
      for (int s = $urandom_range(0, 3); s > 0; s--) push_w(16'hF0F0);
      for (int n = $urandom_range(1, 6); n > 0; n--) begin
        if ($urandom_range(0, 99) < 8) push_w(16'hF0F0);
        if ($urandom_range(0, 99) < 15) push_w(16'($urandom));
        else push_w(enc(8'($urandom)));
      end
    end
    push_gap(3);
    drive_stream();
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin act = act_a; sn = 2; mb = 2048; fc = bus_a.frame_cnt; ec = bus_a.err_cnt; end
        1: begin act = act_b; sn = 1; mb = 2048; fc = bus_b.frame_cnt; ec = bus_b.err_cnt; end
        default: begin act = act_c; sn = 2; mb = 4; fc = bus_c.frame_cnt; ec = bus_c.err_cnt; end
      endcase
      run_model(sn, mb);
      n_cmp++;
      if (act.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", d, act.size(), exp_q.size());
      end
      for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (act[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_byte%0d: got %h expected %h", d, i, act[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (fc !== 16'(exp_frames)) begin n_fail++; $display("FAIL rand%0d_frame_cnt: got %0d expected %0d", d, fc, exp_frames); end
      n_cmp++;
      if (ec !== 16'(exp_errs)) begin n_fail++; $display("FAIL rand%0d_err_cnt: got %0d expected %0d", d, ec, exp_errs); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_normal();
    test_insufficient_sync();
    test_illegal_pair();
    test_length_limit();
    test_sync_in_data();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
